// File: rtl/wisc_pkg.sv
// Shared types and constants for the write-back stage and register file.
// Optional feature macro used by rf_core: WB_BYPASS_EN (write-before-read bypass).
package wisc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);

  // Write-back source select encodings
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;
  localparam logic [1:0] WB_SEL_ILL = 2'b11;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic              valid;
    logic [1:0]        wb_sel;
    logic              reg_we;
    logic [REG_AW-1:0] reg_dst;
    logic              halt;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] pc2;
  } mem_wb_t;

  // Write-back value; the illegal encoding falls back to the ALU result
  function automatic logic [DATA_W-1:0] wb_select(input mem_wb_t r);
    logic [DATA_W-1:0] v;
    v = r.alu;
    case (r.wb_sel)
      WB_SEL_ALU: v = r.alu;
      WB_SEL_MEM: v = r.mem;
      WB_SEL_PC:  v = r.pc2;
      default:    v = r.alu;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rf_core.sv
// Architectural register file: NUM_REGS x DATA_W, one write port, two
// combinational read ports, synchronous reset of every register.
// Macro WB_BYPASS_EN: a read of the register being written this cycle returns
// the write data instead of the stored value.
module rf_core
  import wisc_pkg::*;
#(
  parameter int unsigned RF_DATA_W = DATA_W,
  parameter int unsigned RF_REGS   = NUM_REGS,
  parameter int unsigned RF_AW     = REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [RF_AW-1:0]     waddr,
  input  logic [RF_DATA_W-1:0] wdata,
  input  logic [RF_AW-1:0]     raddr1,
  input  logic [RF_AW-1:0]     raddr2,
  output logic [RF_DATA_W-1:0] rdata1,
  output logic [RF_DATA_W-1:0] rdata2
);

  logic [RF_DATA_W-1:0] regs [RF_REGS];

  // Register array: clear on reset, otherwise single-port write (R0 included)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RF_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational read ports, optionally bypassing the in-flight write
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
`ifdef WB_BYPASS_EN
    if (we && (raddr1 == waddr)) rdata1 = wdata;
    if (we && (raddr2 == waddr)) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: MEM/WB pipeline register, write-back select, sticky halt,
// and the architectural register file (rf_core).
// Macro WB_BYPASS_EN (passed to rf_core): same-cycle write-to-read bypass.
module wb_stage_regfile
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic [1:0]        wb_sel,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_dst,
  input  logic              halt_in,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic              err
);

  mem_wb_t mw;

  // MEM/WB capture with priority rst > halted > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mw <= '0;
    end else if (halted) begin
      mw.valid <= 1'b0;
    end else if (flush) begin
      mw.valid <= 1'b0;
    end else if (!stall) begin
      mw.valid   <= in_valid;
      mw.wb_sel  <= wb_sel;
      mw.reg_we  <= reg_we;
      mw.reg_dst <= reg_dst;
      mw.halt    <= halt_in;
      mw.alu     <= alu_result;
      mw.mem     <= mem_rdata;
      mw.pc2     <= pc_plus2;
    end
  end

  // Sticky halt: set once a valid HALT sits in write-back, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (mw.valid && mw.halt) begin
      halted <= 1'b1;
    end
  end

  // Write-back outputs derived from the registered stage contents
  always_comb begin
    wb_valid = mw.valid;
    wb_en    = mw.valid & mw.reg_we;
    wb_reg   = mw.reg_dst;
    wb_data  = wb_select(mw);
    err      = mw.valid & (mw.wb_sel == WB_SEL_ILL);
  end

  rf_core #(
    .RF_DATA_W (DATA_W),
    .RF_REGS   (NUM_REGS),
    .RF_AW     (REG_AW)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_reg),
    .wdata  (wb_data),
    .raddr1 (rd_addr1),
    .raddr2 (rd_addr2),
    .rdata1 (rd_data1),
    .rdata2 (rd_data2)
  );

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench for wb_stage_regfile: an instruction-level model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_wb_stage_regfile;
  import wisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, reg_we, halt_in;
  logic [15:0] mem_rdata, alu_result, pc_plus2;
  logic [1:0]  wb_sel;
  logic [2:0]  reg_dst, rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2, wb_data;
  logic        wb_valid, wb_en, halted, err;
  logic [2:0]  wb_reg;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  wb_stage_regfile dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .mem_rdata(mem_rdata), .alu_result(alu_result), .pc_plus2(pc_plus2),
    .wb_sel(wb_sel), .reg_we(reg_we), .reg_dst(reg_dst), .halt_in(halt_in),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .halted(halted), .err(err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The instruction currently in write-back, whether its fields are defined,
  // the register contents and the halt flag.
  bit          m_ready = 0;
  bit          m_valid, m_known, m_halted;
  bit          m_we, m_halt;
  logic [1:0]  m_sel;
  logic [2:0]  m_dst;
  logic [15:0] m_alu, m_mem, m_pc2;
  logic [15:0] m_regs [8];

  function automatic logic [15:0] m_value();
    if (m_sel == 2'd1) return m_mem;
    if (m_sel == 2'd2) return m_pc2;
    return m_alu;
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
`ifdef WB_BYPASS_EN
    if (m_valid && m_we && a == m_dst) return m_value();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1; m_valid = 0; m_known = 1; m_halted = 0;
      m_we = 0; m_halt = 0; m_sel = 0; m_dst = 0;
      m_alu = 0; m_mem = 0; m_pc2 = 0;
      foreach (m_regs[i]) m_regs[i] = 16'h0;
    end else if (m_ready) begin
      bit was_halted;
      was_halted = m_halted;
      if (m_valid && m_we) m_regs[m_dst] = m_value();
      if (m_valid && m_halt) m_halted = 1;
      if (was_halted || flush) begin
        m_valid = 0; m_known = 0;
      end else if (!stall) begin
        m_valid = in_valid; m_known = 1;
        m_we = reg_we; m_halt = halt_in; m_sel = wb_sel; m_dst = reg_dst;
        m_alu = alu_result; m_mem = mem_rdata; m_pc2 = pc_plus2;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ready) begin
      chk("wb_valid", {15'd0, wb_valid}, {15'd0, m_valid});
      chk("wb_en",    {15'd0, wb_en},    {15'd0, m_valid & m_we});
      chk("halted",   {15'd0, halted},   {15'd0, m_halted});
      chk("err",      {15'd0, err},      {15'd0, m_valid & (m_sel == 2'd3)});
      if (m_known) begin
        chk("wb_reg",  {13'd0, wb_reg}, {13'd0, m_dst});
        chk("wb_data", wb_data, m_value());
      end
      chk("rd_data1", rd_data1, m_read(rd_addr1));
      chk("rd_data2", rd_data2, m_read(rd_addr2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [15:0] alu, input logic [15:0] mem,
                       input logic [15:0] pc2, input logic [2:0] dst, input logic we,
                       input logic hlt);
    in_valid = 1; wb_sel = sel; alu_result = alu; mem_rdata = mem; pc_plus2 = pc2;
    reg_dst = dst; reg_we = we; halt_in = hlt;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; in_valid = 0; reg_we = 0; halt_in = 0;
    mem_rdata = 0; alu_result = 0; pc_plus2 = 0; wb_sel = 0; reg_dst = 0;
    rd_addr1 = 0; rd_addr2 = 0;
    tick(); tick();
    rst = 0;
    chk("reset wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("reset wb_data", wb_data, 16'h0000);
    chk("reset halted", {15'd0, halted}, 16'd0);
    chk("reset R0", rd_data1, 16'h0000);

    // 1: ALU write to R3
    issue(2'b00, 16'h1234, 16'h0000, 16'h0000, 3'd3, 1, 0);
    tick();
    chk("alu wb_data", wb_data, 16'h1234);
    chk("alu wb_en", {15'd0, wb_en}, 16'd1);
    in_valid = 0; rd_addr1 = 3;
    tick();
    chk("alu R3", rd_data1, 16'h1234);

    // 2: load to R5, read during the write-back cycle
    issue(2'b01, 16'h0001, 16'hBEEF, 16'h0000, 3'd5, 1, 0);
    tick();
    in_valid = 0; rd_addr2 = 5;
    #1;
`ifdef WB_BYPASS_EN
    chk("load bypass R5", rd_data2, 16'hBEEF);
`else
    chk("load no-bypass R5", rd_data2, 16'h0000);
`endif
    tick();
    chk("load R5", rd_data2, 16'hBEEF);

    // 3: stall holds, flush wins over stall
    issue(2'b00, 16'h0007, 16'h0000, 16'h0000, 3'd2, 1, 0);
    tick();
    issue(2'b01, 16'h0099, 16'h5A5A, 16'h0000, 3'd6, 1, 0);
    stall = 1;
    tick(); tick(); tick();
    chk("stall wb_data", wb_data, 16'h0007);
    chk("stall wb_reg", {13'd0, wb_reg}, 16'd2);
    chk("stall wb_en", {15'd0, wb_en}, 16'd1);
    flush = 1;
    tick();
    chk("flush wb_valid", {15'd0, wb_valid}, 16'd0);
    chk("flush wb_en", {15'd0, wb_en}, 16'd0);
    stall = 0; flush = 0; in_valid = 0; rd_addr1 = 2; rd_addr2 = 6;
    tick(); tick();
    chk("flush R2", rd_data1, 16'h0007);
    chk("flush R6 untouched", rd_data2, 16'h0000);

    // 4: JAL link to R7, then illegal select writing R4
    issue(2'b10, 16'h1111, 16'h2222, 16'h0042, 3'd7, 1, 0);
    tick();
    issue(2'b11, 16'h0ABC, 16'h3333, 16'h4444, 3'd4, 1, 0);
    rd_addr1 = 7; rd_addr2 = 4;
    tick();
    chk("jal R7", rd_data1, 16'h0042);
    chk("ill err", {15'd0, err}, 16'd1);
    chk("ill wb_data", wb_data, 16'h0ABC);
    in_valid = 0;
    tick();
    chk("ill err clears", {15'd0, err}, 16'd0);
    chk("ill R4", rd_data2, 16'h0ABC);

    // 6: reset while a write of FFFF to R4 is in write-back
    issue(2'b00, 16'hFFFF, 16'h0000, 16'h0000, 3'd4, 1, 0);
    tick();
    chk("midop wb_en", {15'd0, wb_en}, 16'd1);
    rst = 1; in_valid = 0;
    tick();
    rst = 0;
    #1;
    chk("midop R4", rd_data2, 16'h0000);
    chk("midop R7", rd_data1, 16'h0000);
    chk("midop wb_en", {15'd0, wb_en}, 16'd0);

    // 5: HALT that also writes R3; later writes to R1 are dropped
    issue(2'b00, 16'h5555, 16'h0000, 16'h0000, 3'd3, 1, 1);
    tick();
    chk("halt not yet", {15'd0, halted}, 16'd0);
    in_valid = 0; halt_in = 0;
    tick();
    chk("halted set", {15'd0, halted}, 16'd1);
    issue(2'b00, 16'h2222, 16'h0000, 16'h0000, 3'd1, 1, 0);
    tick();
    chk("halted no capture", {15'd0, wb_valid}, 16'd0);
    tick(); tick();
    in_valid = 0; rd_addr1 = 1; rd_addr2 = 3;
    #1;
    chk("halted R1", rd_data1, 16'h0000);
    chk("halt R3 written", rd_data2, 16'h5555);
    rst = 1;
    tick();
    rst = 0;
    chk("rst halted", {15'd0, halted}, 16'd0);
    chk("rst R3", rd_data2, 16'h0000);

    // R0 is writable
    issue(2'b00, 16'hA5A5, 16'h0000, 16'h0000, 3'd0, 1, 0);
    rd_addr1 = 0;
    tick();
    in_valid = 0;
    tick();
    chk("R0 write", rd_data1, 16'hA5A5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
